// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//
// 32-bit down-counting timer with three memory-mapped registers and a
// maskable interrupt output.
//
//   CTRL   (addr 0) : [3] IM (irq mask), [2:1] Mode, [0] Enable
//   PRESET (addr 1) : reload value, read/write
//   COUNT  (addr 2) : current count, read-only
//   addr 3          : unused, reads 0
//
// Mode 2'b01 reloads automatically after each expiry and emits a one-cycle
// irq pulse.  Every other Mode value is one-shot: Enable is cleared and irq
// stays high until the next register write.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-high reset
//   addr   in   2   register word offset
//   we     in   1   register write enable
//   din    in  32   write data
//   dout   out 32   combinational read data for addr
//   irq    out  1   interrupt request (IM & irq_flag)
// -----------------------------------------------------------------------------
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CNT  = 2'd2;
    localparam logic [1:0] INT  = 2'd3;

    localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [1:0]  state;
    logic        irq_flag;

    logic        enable;
    logic        irq_mask;
    logic [1:0]  mode;

    assign enable   = ctrl[0];
    assign mode     = ctrl[2:1];
    assign irq_mask = ctrl[3];

    // A register write takes priority over the FSM: the FSM is frozen for
    // that cycle, so the write and the INT state can never both touch CTRL.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            state    <= IDLE;
            irq_flag <= 1'b0;
        end else if (we) begin
            irq_flag <= 1'b0;
            case (addr)
                2'd0:    ctrl   <= din[3:0];
                2'd1:    preset <= din;
                default: ;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // Terminal count: a preset of 0 or 1 expires on the
                        // first CNT cycle, and the count never wraps below 0.
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    if (mode == MODE_AUTO_RELOAD) begin
                        // Enable stays set, so IDLE moves straight to LOAD.
                        irq_flag <= 1'b0;
                    end else begin
                        ctrl[0] <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Both terms come from flops, so there is no path from din/we to irq,
    // while clearing IM masks the interrupt without touching irq_flag.
    assign irq = irq_mask & irq_flag;

    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd0:    dout = {28'd0, ctrl};
            2'd1:    dout = preset;
            2'd2:    dout = count;
            default: dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//
// Self-checking bench for timer_counter.  A reference model tracks the timer
// as "steps since the run began": once a run has loaded value L, it expires
// on step L+2 (or step 3 for L<=1), and the count at any step in between is
// L-(step-2).  After every clock edge the bench compares irq and all four
// read addresses against that model, then runs directed scenarios followed
// by randomized register traffic.
// -----------------------------------------------------------------------------
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    longint      m_step;   // 0 = not running, 1 = about to load, >=2 running
    longint      m_load;   // value captured at load
    longint      m_fire;   // step on which the run expires

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_dout(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(input logic r, input logic w,
                                       input logic [1:0] a, input logic [31:0] d);
        if (r) begin
            m_ctrl   = 4'd0;
            m_preset = 32'd0;
            m_count  = 32'd0;
            m_flag   = 1'b0;
            m_step   = 0;
        end else if (w) begin
            m_flag = 1'b0;
            if (a == 2'd0) m_ctrl = d[3:0];
            else if (a == 2'd1) m_preset = d;
        end else if (m_step == 0) begin
            if (m_ctrl[0]) m_step = 1;
        end else if (m_step == 1) begin
            m_load  = longint'(m_preset);
            m_count = m_preset;
            m_fire  = (m_load >= 2) ? m_load + 2 : 3;
            m_step  = 2;
        end else if (m_step < m_fire) begin
            if (!m_ctrl[0]) begin
                m_step = 0;
            end else begin
                m_step++;
                m_count = (m_step >= m_fire) ? 32'd0 : 32'(m_load - (m_step - 2));
                if (m_step == m_fire) m_flag = 1'b1;
            end
        end else begin
            if (m_ctrl[2:1] == 2'b01) m_flag = 1'b0;
            else m_ctrl[0] = 1'b0;
            m_step = 0;
        end
    endfunction

    string reg_name [4] = '{"dout_ctrl", "dout_preset", "dout_count", "dout_unused"};

    // One clock cycle: apply inputs, clock, update model, compare everything.
    task automatic cyc(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
        reset = r;
        we    = w;
        addr  = a;
        din   = d;
        @(posedge clk);
        model_edge(r, w, a, d);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        chk("irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_flag});
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            #1;
            chk(reg_name[i], dout, m_dout(2'(i)));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses[$];
        logic [31:0] frozen;

        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        din   = 32'd0;

        // Reset state
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF);   // reset overrides a write
        chk("reset_irq", {31'd0, irq}, 32'd0);

        // One-shot: PRESET=5, CTRL=IM|Enable
        cyc(1'b0, 1'b1, 2'd1, 32'd5);
        cyc(1'b0, 1'b1, 2'd0, 32'h9);
        n = 0;
        while (!irq && n < 50) begin
            idle(1);
            n++;
        end
        chk("oneshot_latency", n, 32'd7);
        idle(4);
        chk("oneshot_irq_held", {31'd0, irq}, 32'd1);
        addr = 2'd0; #1;
        chk("oneshot_enable_cleared", dout, 32'h8);

        // Acknowledge by writing PRESET
        cyc(1'b0, 1'b1, 2'd1, 32'd7);
        chk("ack_irq_low", {31'd0, irq}, 32'd0);
        idle(12);
        chk("ack_stays_idle", {31'd0, irq}, 32'd0);

        // Auto-reload: PRESET=3, CTRL=IM|Mode01|Enable
        cyc(1'b0, 1'b1, 2'd1, 32'd3);
        cyc(1'b0, 1'b1, 2'd0, 32'hB);
        for (int i = 1; i <= 30; i++) begin
            idle(1);
            if (irq) pulses.push_back(i);
        end
        chk("ar_pulse_count_ge4", {31'd0, pulses.size() >= 4}, 32'd1);
        if (pulses.size() >= 1) chk("ar_first_pulse", pulses[0], 32'd5);
        for (int i = 1; i < pulses.size(); i++) chk("ar_period", pulses[i] - pulses[i-1], 32'd6);
        cyc(1'b0, 1'b1, 2'd0, 32'h0);
        idle(3);

        // Disable mid-count
        cyc(1'b0, 1'b1, 2'd1, 32'd100);
        cyc(1'b0, 1'b1, 2'd0, 32'h9);
        idle(10);
        cyc(1'b0, 1'b1, 2'd0, 32'h8);
        idle(20);
        addr = 2'd2; #1;
        frozen = dout;
        chk("disable_count_frozen", frozen, 32'd92);
        chk("disable_no_irq", {31'd0, irq}, 32'd0);

        // Masked expiry with PRESET=0, then IM set by a write
        cyc(1'b0, 1'b1, 2'd1, 32'd0);
        cyc(1'b0, 1'b1, 2'd0, 32'h1);
        idle(6);
        chk("masked_irq_low", {31'd0, irq}, 32'd0);
        cyc(1'b0, 1'b1, 2'd0, 32'h8);
        idle(3);
        chk("unmask_after_clear_low", {31'd0, irq}, 32'd0);

        // Reset mid-count
        cyc(1'b0, 1'b1, 2'd1, 32'd50);
        cyc(1'b0, 1'b1, 2'd0, 32'h9);
        idle(19);
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i); #1;
            chk("midreset_dout", dout, 32'd0);
        end
        idle(60);
        chk("midreset_no_irq", {31'd0, irq}, 32'd0);

        // Randomized register traffic
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic        w;
            logic [1:0]  a;
            logic [31:0] d;
            r = ($urandom_range(0, 199) == 0);
            w = ($urandom_range(0, 5) == 0);
            a = 2'($urandom_range(0, 3));
            if (a == 2'd1) d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                                            : 32'($urandom_range(0, 6));
            else d = $urandom;
            cyc(r, w, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
